ysyx_22040237_ifu: RTL and testbench



---
 rtl/ysyx_22040237_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: holds the PC, issues one-outstanding word fetches and
// hands each returned instruction to decode over a valid/ready handshake.
module ysyx_22040237_ifu #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [63:0]     fetch_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic              boot_q, boot_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [ILEN-1:0]   inst_q, inst_d;
  logic [63:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]   tgt;

  assign tgt = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      boot_q   <= 1'b0;
      kill_q   <= 1'b0;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      boot_q   <= boot_d;
      kill_q   <= kill_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    boot_d   = boot_q;
    kill_d   = kill_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_BOOT: begin
        // Idle one full cycle after reset release before the first request.
        if (boot_q) state_d = S_REQ;
        else        boot_d  = 1'b1;
      end
      S_REQ: begin
        if (req_ready) begin
          state_d = S_WAIT;
          if (redirect_valid) begin
            kill_d = 1'b1;
            pc_d   = tgt;
          end
        end else if (redirect_valid) begin
          pc_d = tgt;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = tgt;
          end else begin
            pc_out_d = pc_q;
            inst_d   = resp_data;
            state_d  = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = tgt;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          cnt_d   = cnt_q + 64'd1;
          pc_d    = redirect_valid ? tgt : pc_q + XLEN'(4);
          state_d = S_REQ;
        end else if (redirect_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign req_valid  = (state_q == S_REQ);
  assign req_addr   = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign pc         = pc_out_q;
  assign inst       = inst_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for ysyx_22040237_ifu with a small one-outstanding memory model.
module tb_ysyx_22040237_ifu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] fetch_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  logic        mem_ovr = 1'b0;
  int          req_cnt = 0;
  logic [63:0] req_log [0:15];

  ysyx_22040237_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inst(input string tag, input logic [63:0] epc, input logic [31:0] einst);
    int n = 0;
    do begin
      step();
      n++;
    end while (inst_valid !== 1'b1 && n < 12);
    chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_inst"}, 64'(inst), 64'(einst));
  endtask

  // Memory: data is ~addr, delivered mem_lat cycles after acceptance; aborted by reset.
  initial begin : mem
    logic [63:0] a;
    bit          ab;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) begin
        a = req_addr;
        if (req_cnt < 16) req_log[req_cnt] = a;
        req_cnt++;
        @(posedge clk); #2;
        ab = !rst_n;
        for (int i = 1; i < mem_lat; i++) begin
          @(posedge clk); #2;
          if (!rst_n) ab = 1'b1;
        end
        if (!ab) begin
          resp_valid = 1'b1;
          resp_data  = mem_ovr ? 32'hDEAD_BEEF : ~a[31:0];
          @(posedge clk); #2;
          resp_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_addr", req_addr, 64'h8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_fetch_cnt", fetch_cnt, 64'd0);

    // Streaming fetch, zero-stall memory
    req_ready = 1'b1; inst_ready = 1'b1; rst_n = 1'b1;
    step();
    chk("boot_req_valid", 64'(req_valid), 64'd0);
    step();
    chk("first_req_valid", 64'(req_valid), 64'd1);
    chk("first_req_addr", req_addr, 64'h8000_0000);
    wait_inst("i0", 64'h8000_0000, 32'h7FFF_FFFF);
    wait_inst("i1", 64'h8000_0004, 32'h7FFF_FFFB);
    wait_inst("i2", 64'h8000_0008, 32'h7FFF_FFF7);
    step();
    chk("cnt3", fetch_cnt, 64'd3);
    req_ready = 1'b0;
    chk("log0", req_log[0], 64'h8000_0000);
    chk("log1", req_log[1], 64'h8000_0004);
    chk("log2", req_log[2], 64'h8000_0008);

    // Request stalled by memory
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req_valid", 64'(req_valid), 64'd1);
      chk("stall_req_addr", req_addr, 64'h8000_000C);
    end
    chk("stall_req_cnt", 64'(req_cnt), 64'd3);
    inst_ready = 1'b0; req_ready = 1'b1;
    step();
    chk("accept_req_valid", 64'(req_valid), 64'd0);
    chk("accept_req_cnt", 64'(req_cnt), 64'd4);
    chk("log3", req_log[3], 64'h8000_000C);

    // Decode back-pressure
    wait_inst("i3", 64'h8000_000C, 32'h7FFF_FFF3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_inst_valid", 64'(inst_valid), 64'd1);
      chk("bp_pc", pc, 64'h8000_000C);
      chk("bp_inst", 64'(inst), 64'h7FFF_FFF3);
      chk("bp_req_valid", 64'(req_valid), 64'd0);
      chk("bp_cnt", fetch_cnt, 64'd3);
    end
    inst_ready = 1'b1;
    step();
    chk("bp_done_cnt", fetch_cnt, 64'd4);
    chk("bp_done_inst_valid", 64'(inst_valid), 64'd0);
    chk("bp_done_req_addr", req_addr, 64'h8000_0010);

    // Redirect coincident with the decode handshake
    wait_inst("i4", 64'h8000_0010, 32'h7FFF_FFEF);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    step();
    redirect_valid = 1'b0;
    chk("hold_redir_cnt", fetch_cnt, 64'd5);
    chk("hold_redir_req_valid", 64'(req_valid), 64'd1);
    chk("hold_redir_req_addr", req_addr, 64'h8000_0100);

    // Redirect while waiting; late response must be dropped
    mem_lat = 4; mem_ovr = 1'b1;
    step();
    chk("w_redir_req_valid", 64'(req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_redir_inst_valid", 64'(inst_valid), 64'd0);
      chk("w_redir_inst", 64'(inst), 64'h7FFF_FFEF);
      step();
    end
    chk("kill_req_valid", 64'(req_valid), 64'd1);
    chk("kill_req_addr", req_addr, 64'h8000_0200);
    chk("kill_inst_valid", 64'(inst_valid), 64'd0);
    mem_ovr = 1'b0; mem_lat = 1;
    wait_inst("i5", 64'h8000_0200, 32'h7FFF_FDFF);
    step();
    chk("cnt6", fetch_cnt, 64'd6);

    // Reset during WAIT
    mem_lat = 3;
    step();
    chk("prerst_req_valid", 64'(req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("wrst_req_valid", 64'(req_valid), 64'd0);
    chk("wrst_req_addr", req_addr, 64'h8000_0000);
    chk("wrst_inst_valid", 64'(inst_valid), 64'd0);
    chk("wrst_pc", pc, 64'd0);
    chk("wrst_inst", 64'(inst), 64'd0);
    chk("wrst_cnt", fetch_cnt, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_boot_req_valid", 64'(req_valid), 64'd0);
    chk("rel_boot_resp", 64'(resp_valid), 64'd0);
    step();
    chk("rel_req_valid", 64'(req_valid), 64'd1);
    chk("rel_req_addr", req_addr, 64'h8000_0000);
    chk("rel_cnt", fetch_cnt, 64'd0);
    req_ready = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
